// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with operand forwarding, load-use bubble, hold and flush
module id_ex_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  output logic        id_ready,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_rd,
  input  logic [31:0] id_rs_data,
  input  logic [31:0] id_rt_data,
  input  logic [31:0] id_imm,
  input  logic [4:0]  id_shamt,
  input  logic        id_alusrc,
  input  logic [1:0]  id_ALUop,
  input  logic [5:0]  id_Func,
  input  logic        id_regwrite,
  input  logic        id_memread,
  input  logic        id_memwrite,
  input  logic [31:0] ex_result,
  input  logic        exmem_regwrite,
  input  logic [4:0]  exmem_rd,
  input  logic [31:0] exmem_data,
  input  logic        memwb_regwrite,
  input  logic [4:0]  memwb_rd,
  input  logic [31:0] memwb_data,
  input  logic        hold,
  input  logic        flush,
  output logic [31:0] A,
  output logic [31:0] B,
  output logic [1:0]  ALUop,
  output logic [5:0]  Func,
  output logic        ex_valid,
  output logic [4:0]  ex_rd,
  output logic        ex_regwrite,
  output logic        ex_memread,
  output logic        ex_memwrite,
  output logic [31:0] ex_store_data
);

  typedef struct packed {
    logic        valid;
    logic        regwrite;
    logic        memread;
    logic        memwrite;
    logic [4:0]  rd;
    logic [1:0]  aluop;
    logic [5:0]  func;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] store_data;
  } slot_t;

  slot_t       slot_q, slot_d, load_slot;
  logic [31:0] rs_fwd, rt_fwd;
  logic        load_use, fixed_shift;

  // A load's data is not ready in EX, so EX forwarding excludes memread instructions.
  function automatic logic [31:0] fwd(input logic [4:0] s, input logic [31:0] rf,
                                      input slot_t cur, input logic [31:0] exr,
                                      input logic xm_we, input logic [4:0] xm_rd,
                                      input logic [31:0] xm_d, input logic mw_we,
                                      input logic [4:0] mw_rd, input logic [31:0] mw_d);
    logic [31:0] v;
    v = rf;
    if (s != 5'd0) begin
      if (cur.valid && cur.regwrite && !cur.memread && cur.rd == s) v = exr;
      else if (xm_we && xm_rd == s)                                v = xm_d;
      else if (mw_we && mw_rd == s)                                v = mw_d;
    end
    return v;
  endfunction

  assign rs_fwd = fwd(id_rs, id_rs_data, slot_q, ex_result, exmem_regwrite, exmem_rd,
                      exmem_data, memwb_regwrite, memwb_rd, memwb_data);
  assign rt_fwd = fwd(id_rt, id_rt_data, slot_q, ex_result, exmem_regwrite, exmem_rd,
                      exmem_data, memwb_regwrite, memwb_rd, memwb_data);

  assign load_use = id_valid && slot_q.valid && slot_q.memread && (slot_q.rd != 5'd0) &&
                    ((slot_q.rd == id_rs) || (slot_q.rd == id_rt));
  assign id_ready = !hold && !load_use;

  assign fixed_shift = (id_ALUop == 2'b10) && (id_Func[5:2] == 4'b0000);

  always_comb begin
    load_slot            = '0;
    load_slot.valid      = 1'b1;
    load_slot.regwrite   = id_regwrite;
    load_slot.memread    = id_memread;
    load_slot.memwrite   = id_memwrite;
    load_slot.rd         = id_rd;
    load_slot.aluop      = id_ALUop;
    load_slot.func       = id_Func;
    load_slot.a          = fixed_shift ? {27'b0, id_shamt} : rs_fwd;
    load_slot.b          = id_alusrc ? id_imm : rt_fwd;
    load_slot.store_data = rt_fwd;
  end

  // flush outranks hold so a squashed instruction never survives a freeze.
  always_comb begin
    slot_d = '0;
    if (flush)         slot_d = '0;
    else if (hold)     slot_d = slot_q;
    else if (load_use) slot_d = '0;
    else if (id_valid) slot_d = load_slot;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) slot_q <= '0;
    else        slot_q <= slot_d;
  end

  assign A             = slot_q.a;
  assign B             = slot_q.b;
  assign ALUop         = slot_q.aluop;
  assign Func          = slot_q.func;
  assign ex_valid      = slot_q.valid;
  assign ex_rd         = slot_q.rd;
  assign ex_regwrite   = slot_q.regwrite;
  assign ex_memread    = slot_q.memread;
  assign ex_memwrite   = slot_q.memwrite;
  assign ex_store_data = slot_q.store_data;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - self-checking bench for id_ex_stage: vector table, corner sequences, random model
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, id_ready;
  logic [4:0]  id_rs, id_rt, id_rd, id_shamt;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic        id_alusrc, id_regwrite, id_memread, id_memwrite;
  logic [1:0]  id_ALUop;
  logic [5:0]  id_Func;
  logic [31:0] ex_result, exmem_data, memwb_data;
  logic        exmem_regwrite, memwb_regwrite;
  logic [4:0]  exmem_rd, memwb_rd;
  logic        hold, flush;
  logic [31:0] A, B, ex_store_data;
  logic [1:0]  ALUop;
  logic [5:0]  Func;
  logic        ex_valid, ex_regwrite, ex_memread, ex_memwrite;
  logic [4:0]  ex_rd;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ready(id_ready),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_shamt(id_shamt), .id_alusrc(id_alusrc), .id_ALUop(id_ALUop), .id_Func(id_Func),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
    .ex_result(ex_result), .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd),
    .exmem_data(exmem_data), .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd),
    .memwb_data(memwb_data), .hold(hold), .flush(flush),
    .A(A), .B(B), .ALUop(ALUop), .Func(Func), .ex_valid(ex_valid), .ex_rd(ex_rd),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
    .ex_store_data(ex_store_data)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_valid = 0; id_rs = 0; id_rt = 0; id_rd = 0; id_shamt = 0;
    id_rs_data = 0; id_rt_data = 0; id_imm = 0; id_alusrc = 0;
    id_regwrite = 0; id_memread = 0; id_memwrite = 0; id_ALUop = 0; id_Func = 0;
    ex_result = 0; exmem_regwrite = 0; exmem_rd = 0; exmem_data = 0;
    memwb_regwrite = 0; memwb_rd = 0; memwb_data = 0; hold = 0; flush = 0;
  endtask

  // Each vector: a producer instruction is latched first, then the consumer is applied.
  typedef struct {
    logic [4:0]  p_rd;  logic p_rw; logic p_mr;
    logic [4:0]  rs;    logic [4:0] rt;
    logic [31:0] rs_d;  logic [31:0] rt_d; logic [31:0] imm;
    logic [4:0]  shamt; logic alusrc; logic [1:0] aluop; logic [5:0] func;
    logic [31:0] exr;
    logic        xm_rw; logic [4:0] xm_rd; logic [31:0] xm_d;
    logic        mw_rw; logic [4:0] mw_rd; logic [31:0] mw_d;
    logic        e_rdy; logic e_val;
    logic [31:0] e_a;   logic [31:0] e_b; logic [31:0] e_sd;
  } vec_t;

  vec_t vecs[11];

  // Reference model state: the instruction visible at the ALU inputs.
  typedef struct {
    logic valid, rw, mr, mw;
    logic [4:0] rd;
    logic [1:0] aluop;
    logic [5:0] func;
    logic [31:0] a, b, sd;
  } mslot_t;

  mslot_t m;

  function automatic logic [31:0] m_fwd(input mslot_t cur, input logic [4:0] s, input logic [31:0] rf);
    logic        en[3];
    logic [4:0]  rd[3];
    logic [31:0] dat[3];
    if (s == 0) return rf;
    en[0] = cur.valid & cur.rw & ~cur.mr; rd[0] = cur.rd;   dat[0] = ex_result;
    en[1] = exmem_regwrite;               rd[1] = exmem_rd; dat[1] = exmem_data;
    en[2] = memwb_regwrite;               rd[2] = memwb_rd; dat[2] = memwb_data;
    for (int k = 0; k < 3; k++) if (en[k] && rd[k] == s) return dat[k];
    return rf;
  endfunction

  function automatic logic m_lu(input mslot_t cur);
    return id_valid & cur.valid & cur.mr & (cur.rd != 0) & (cur.rd == id_rs || cur.rd == id_rt);
  endfunction

  function automatic mslot_t m_next(input mslot_t cur);
    mslot_t n;
    n = '{default: 0};
    if (flush) return n;
    if (hold) return cur;
    if (m_lu(cur) || !id_valid) return n;
    n.valid = 1; n.rw = id_regwrite; n.mr = id_memread; n.mw = id_memwrite;
    n.rd = id_rd; n.aluop = id_ALUop; n.func = id_Func;
    n.a  = (id_ALUop == 2 && id_Func < 6'd4) ? 32'(id_shamt) : m_fwd(cur, id_rs, id_rs_data);
    n.sd = m_fwd(cur, id_rt, id_rt_data);
    n.b  = id_alusrc ? id_imm : n.sd;
    return n;
  endfunction

  initial begin
    vecs[0]  = '{3,1,0, 3,5, 32'h1000,32'h55,0, 0,0,0,6'h20, 32'h11, 1,3,32'h22, 0,0,0, 1,1, 32'h11,32'h55,32'h55};
    vecs[1]  = '{3,0,0, 3,5, 32'h1000,32'h55,0, 0,0,0,6'h20, 32'h11, 1,3,32'h22, 0,0,0, 1,1, 32'h22,32'h55,32'h55};
    vecs[2]  = '{0,1,0, 0,0, 32'h1234,32'h5678,0, 0,0,0,6'h20, 32'h11, 1,0,32'h22, 1,0,32'h33, 1,1, 32'h1234,32'h5678,32'h5678};
    vecs[3]  = '{0,0,0, 6,7, 32'hFFFF,32'h3,0, 7,0,2,6'h00, 0, 0,0,0, 0,0,0, 1,1, 32'h7,32'h3,32'h3};
    vecs[4]  = '{0,0,0, 6,7, 32'hFFFF,32'h3,0, 7,0,2,6'h04, 0, 0,0,0, 0,0,0, 1,1, 32'hFFFF,32'h3,32'h3};
    vecs[5]  = '{0,0,0, 6,7, 32'hFFFF,32'h3,32'hFFFFFFF0, 7,1,2,6'h20, 0, 0,0,0, 0,0,0, 1,1, 32'hFFFF,32'hFFFFFFF0,32'h3};
    vecs[6]  = '{0,0,0, 8,9, 32'h100,32'h5,32'h10, 0,1,0,6'h00, 0, 0,0,0, 1,9,32'hABCD, 1,1, 32'h100,32'h10,32'hABCD};
    vecs[7]  = '{0,0,0, 8,9, 32'h100,32'h5,0, 0,0,0,6'h20, 0, 1,9,32'h22, 1,9,32'h33, 1,1, 32'h100,32'h22,32'h22};
    vecs[8]  = '{4,1,1, 1,4, 32'h1,32'h2,0, 0,0,0,6'h20, 0, 0,0,0, 0,0,0, 0,0, 0,0,0};
    vecs[9]  = '{0,1,1, 0,0, 32'h1,32'h2,0, 0,0,0,6'h20, 0, 0,0,0, 0,0,0, 1,1, 32'h1,32'h2,32'h2};
    vecs[10] = '{5,1,1, 6,7, 32'h66,32'h77,0, 0,0,0,6'h20, 32'hDEAD, 0,0,0, 0,0,0, 1,1, 32'h66,32'h77,32'h77};

    clear_inputs();
    rst_n = 0;
    repeat (2) tick();
    chk("reset_ex_valid", 32'(ex_valid), 0);
    chk("reset_A", A, 0);
    chk("reset_B", B, 0);
    chk("reset_id_ready", 32'(id_ready), 1);

    // Asynchronous reset mid-cycle while a real instruction is held.
    @(negedge clk); rst_n = 1;
    id_valid = 1; id_rs = 1; id_rt = 2; id_rd = 3; id_rs_data = 32'h42; id_rt_data = 32'h43;
    tick();
    chk("pre_reset_valid", 32'(ex_valid), 1);
    #2 rst_n = 0;
    #1;
    chk("async_reset_valid", 32'(ex_valid), 0);
    chk("async_reset_A", A, 0);
    chk("async_reset_B", B, 0);
    @(negedge clk); rst_n = 1;
    id_rs_data = 5; id_rt_data = 7; id_ALUop = 2'b10; id_Func = 6'b100000;
    tick();
    chk("post_reset_A", A, 5);
    chk("post_reset_B", B, 7);
    chk("post_reset_valid", 32'(ex_valid), 1);

    foreach (vecs[i]) begin
      clear_inputs();
      id_valid = 1; id_rd = vecs[i].p_rd; id_regwrite = vecs[i].p_rw; id_memread = vecs[i].p_mr;
      tick();
      clear_inputs();
      id_valid = 1; id_rd = 10; id_regwrite = 1;
      id_rs = vecs[i].rs; id_rt = vecs[i].rt; id_rs_data = vecs[i].rs_d; id_rt_data = vecs[i].rt_d;
      id_imm = vecs[i].imm; id_shamt = vecs[i].shamt; id_alusrc = vecs[i].alusrc;
      id_ALUop = vecs[i].aluop; id_Func = vecs[i].func; ex_result = vecs[i].exr;
      exmem_regwrite = vecs[i].xm_rw; exmem_rd = vecs[i].xm_rd; exmem_data = vecs[i].xm_d;
      memwb_regwrite = vecs[i].mw_rw; memwb_rd = vecs[i].mw_rd; memwb_data = vecs[i].mw_d;
      #1;
      chk($sformatf("vec%0d_id_ready", i), 32'(id_ready), 32'(vecs[i].e_rdy));
      tick();
      chk($sformatf("vec%0d_ex_valid", i), 32'(ex_valid), 32'(vecs[i].e_val));
      chk($sformatf("vec%0d_A", i), A, vecs[i].e_a);
      chk($sformatf("vec%0d_B", i), B, vecs[i].e_b);
      chk($sformatf("vec%0d_store_data", i), ex_store_data, vecs[i].e_sd);
      chk($sformatf("vec%0d_ex_rd", i), 32'(ex_rd), vecs[i].e_val ? 32'd10 : 32'd0);
    end

    // Hold three cycles with changing decode inputs, then flush while held.
    clear_inputs();
    id_valid = 1; id_rs = 1; id_rt = 2; id_rd = 12; id_rs_data = 32'h77; id_rt_data = 32'h88;
    tick();
    chk("hold_load_A", A, 32'h77);
    hold = 1;
    for (int k = 0; k < 3; k++) begin
      id_rs_data = $urandom; id_rt_data = $urandom; id_rd = 5'(k + 1);
      #1;
      chk("hold_id_ready", 32'(id_ready), 0);
      tick();
      chk("hold_A", A, 32'h77);
      chk("hold_B", B, 32'h88);
      chk("hold_rd", 32'(ex_rd), 12);
      chk("hold_valid", 32'(ex_valid), 1);
    end
    flush = 1;
    tick();
    chk("flush_hold_valid", 32'(ex_valid), 0);
    chk("flush_hold_A", A, 0);

    // Load-use under hold: freeze first, bubble once hold drops, then EX/MEM forward.
    clear_inputs();
    id_valid = 1; id_rd = 4; id_regwrite = 1; id_memread = 1;
    tick();
    clear_inputs();
    id_valid = 1; id_rs = 1; id_rt = 4; id_rd = 6; id_regwrite = 1; id_rs_data = 32'h3;
    id_rt_data = 32'h1; hold = 1;
    repeat (2) tick();
    chk("lu_hold_valid", 32'(ex_valid), 1);
    chk("lu_hold_memread", 32'(ex_memread), 1);
    hold = 0;
    #1;
    chk("lu_id_ready", 32'(id_ready), 0);
    tick();
    chk("lu_bubble_valid", 32'(ex_valid), 0);
    exmem_regwrite = 1; exmem_rd = 4; exmem_data = 32'h99;
    #1;
    chk("lu_after_ready", 32'(id_ready), 1);
    tick();
    chk("lu_fwd_B", B, 32'h99);
    chk("lu_fwd_valid", 32'(ex_valid), 1);

    // Randomized stream against the reference model.
    clear_inputs();
    tick();
    m = '{default: 0};
    m.valid = ex_valid;
    chk("rand_start_valid", 32'(ex_valid), 0);
    for (int c = 0; c < 400; c++) begin
      mslot_t nxt;
      id_valid = ($urandom_range(0, 4) != 0);
      id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
      id_rd = 5'($urandom_range(0, 3));
      id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom;
      id_shamt = 5'($urandom); id_alusrc = 1'($urandom);
      id_ALUop = 2'($urandom); id_Func = ($urandom_range(0, 1) != 0) ? 6'($urandom_range(0, 7)) : 6'($urandom);
      id_regwrite = 1'($urandom); id_memread = ($urandom_range(0, 2) == 0); id_memwrite = 1'($urandom);
      ex_result = $urandom;
      exmem_regwrite = 1'($urandom); exmem_rd = 5'($urandom_range(0, 3)); exmem_data = $urandom;
      memwb_regwrite = 1'($urandom); memwb_rd = 5'($urandom_range(0, 3)); memwb_data = $urandom;
      hold = ($urandom_range(0, 5) == 0); flush = ($urandom_range(0, 7) == 0);
      #1;
      chk("rand_id_ready", 32'(id_ready), 32'(!hold && !m_lu(m)));
      nxt = m_next(m);
      tick();
      m = nxt;
      chk("rand_valid", 32'(ex_valid), 32'(m.valid));
      chk("rand_A", A, m.a);
      chk("rand_B", B, m.b);
      chk("rand_store_data", ex_store_data, m.sd);
      chk("rand_ctrl", {15'b0, ex_rd, ALUop, Func, ex_regwrite, ex_memread, ex_memwrite},
          {15'b0, m.rd, m.aluop, m.func, m.rw, m.mr, m.mw});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
